// File: rtl/addsub_pkg.sv
// Shared state encoding and operation codes for the serial add/subtract sequencer.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/nibble_addsub.sv
// Combinational 4-bit adder/subtractor slice; subtract inverts b and relies on cin=1.
module nibble_addsub
    import addsub_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       op,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c3
);

    logic [3:0] b_eff;
    logic [3:0] low_sum;
    logic [1:0] top_sum;

    assign b_eff = (op == OP_SUB) ? ~b : b;

    // Split at bit 3 so the carry into the MSB is visible for signed overflow.
    assign low_sum = {1'b0, a[2:0]} + {1'b0, b_eff[2:0]} + {3'b000, cin};
    assign c3      = low_sum[3];
    assign top_sum = {1'b0, a[3]} + {1'b0, b_eff[3]} + {1'b0, c3};
    assign s       = {top_sum[0], low_sum[2:0]};
    assign cout    = top_sum[1];

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Wide add/subtract sequenced through one shared nibble slice, least significant nibble first.
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry,
    output logic                   overflow
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            op_reg;
    logic            c_in;
    logic [IW-1:0]   index;
    logic [IW+1:0]   bit_base;
    logic [3:0]      nib_s;
    logic            nib_cout;
    logic            nib_c3;

    assign bit_base = {index, 2'b00};

    nibble_addsub u_slice (
        .a    (a_reg[bit_base +: 4]),
        .b    (b_reg[bit_base +: 4]),
        .op   (op_reg),
        .cin  (c_in),
        .s    (nib_s),
        .cout (nib_cout),
        .c3   (nib_c3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= OP_ADD;
            c_in     <= 1'b0;
            index    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        op_reg <= op;
                        c_in   <= op;
                        index  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    result[bit_base +: 4] <= nib_s;
                    c_in <= nib_cout;
                    // Final slice: latch flags and signal completion in the same edge.
                    if (index == LAST) begin
                        carry    <= nib_cout;
                        overflow <= nib_c3 ^ nib_cout;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
